// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the fetch stage: FSM state codes and the invalid instruction word.
package instruction_fetch_pkg;

  localparam logic [1:0]  FETCH_IDLE    = 2'd0;
  localparam logic [1:0]  FETCH_RUN     = 2'd1;
  localparam logic [1:0]  FETCH_HALT    = 2'd2;
  localparam logic [31:0] INVALID_INSTR = 32'b0;

  typedef enum logic [1:0] {
    StIdle = FETCH_IDLE,
    StRun  = FETCH_RUN,
    StHalt = FETCH_HALT
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, IDLE/RUN/HALT FSM, IF/ID register with valid/ready handoff to decode,
// and a handshake counter. Program memory is read combinationally at imem_addr.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_en,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic [31:0]         count_q, count_d;

  logic slot_free;
  logic handshake;
  logic try_fetch;
  logic load;
  logic halt_entry;

  // Decide whether this cycle fetches a word, halts on a zero word, or does neither.
  always_comb begin
    slot_free  = !valid_q || instr_ready;
    handshake  = valid_q && instr_ready;
    // A fetch is attempted only when a redirect is not overriding it.
    try_fetch  = (state_q == StRun) && fetch_en && slot_free && !redirect_en;
    load       = try_fetch && (imem_data != INVALID_INSTR);
    halt_entry = try_fetch && (imem_data == INVALID_INSTR);
  end

  // Next-state logic for FSM, PC, IF/ID register and handshake counter.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    count_d    = count_q;

    unique case (state_q)
      StIdle:  if (fetch_en) state_d = StRun;
      StRun: begin
        if (!fetch_en)       state_d = StIdle;
        else if (halt_entry) state_d = StHalt;
      end
      StHalt:  if (redirect_en) state_d = StRun;
      default: state_d = StIdle;
    endcase

    if (handshake) count_d = count_q + 32'd1;

    if (redirect_en) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = imem_data;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + PC_WIDTH'(1);  // wraps silently at 2^PC_WIDTH
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  // Registered outputs.
  always_comb begin
    imem_addr   = pc_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
    instr_valid = valid_q;
    halted      = (state_q == StHalt);
    fetch_count = count_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table of per-cycle vectors plus directed sequences
// for wraparound and mid-cycle asynchronous reset.
module tb_instruction_fetch;

  localparam int unsigned PC_WIDTH = 12;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                fetch_en = 1'b0;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_data;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                instr_valid;
  logic                instr_ready = 1'b0;
  logic                redirect_en = 1'b0;
  logic [PC_WIDTH-1:0] redirect_pc = '0;
  logic                halted;
  logic [31:0]         fetch_count;

  // Program memory model: combinational read, word i = A000_0000 | i except word 10 = 0.
  logic [31:0] mem [0:(1<<PC_WIDTH)-1];
  assign imem_data = mem[imem_addr];

  int checks   = 0;
  int failures = 0;

  instruction_fetch #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                fe;
    logic                rdy;
    logic                rde;
    logic [PC_WIDTH-1:0] rpc;
    logic                valid;
    logic [PC_WIDTH-1:0] ipc;
    logic [PC_WIDTH-1:0] addr;
    logic                halt;
    logic [31:0]         cnt;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(logic fe, logic rdy, logic rde, logic [PC_WIDTH-1:0] rpc,
                              logic valid, logic [PC_WIDTH-1:0] ipc, logic [PC_WIDTH-1:0] addr,
                              logic halt, logic [31:0] cnt);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rde = rde; v.rpc = rpc;
    v.valid = valid; v.ipc = ipc; v.addr = addr; v.halt = halt; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Apply inputs at a negedge, let one rising edge pass, sample at the following negedge.
  task automatic step(input logic fe, input logic rdy, input logic rde,
                      input logic [PC_WIDTH-1:0] rpc);
    fetch_en = fe; instr_ready = rdy; redirect_en = rde; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic valid, input logic [PC_WIDTH-1:0] ipc,
                          input logic [PC_WIDTH-1:0] addr, input logic halt,
                          input logic [31:0] cnt);
    chk({tag, " valid"}, {31'b0, instr_valid}, {31'b0, valid});
    chk({tag, " instr_pc"}, {20'b0, instr_pc}, {20'b0, ipc});
    chk({tag, " imem_addr"}, {20'b0, imem_addr}, {20'b0, addr});
    chk({tag, " halted"}, {31'b0, halted}, {31'b0, halt});
    chk({tag, " fetch_count"}, fetch_count, cnt);
    if (valid) chk({tag, " instr"}, instr, 32'hA000_0000 | {20'b0, ipc});
  endtask

  initial begin
    for (int i = 0; i < (1 << PC_WIDTH); i++) mem[i] = 32'hA000_0000 | i;
    mem[10] = 32'b0;

    //            fe   rdy  rde  rpc      | valid ipc     addr    halt cnt
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0, 0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 12'h001, 1'b0, 0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 12'h002, 1'b0, 1);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 12'h003, 1'b0, 2);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 12'h003, 1'b0, 2);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 12'h003, 1'b0, 2);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 12'h003, 1'b0, 2);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 12'h004, 1'b0, 3);
    vecs[8]  = mk(1'b1, 1'b0, 1'b1, 12'h050, 1'b0, 12'h003, 12'h050, 1'b0, 3);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 12'h050, 12'h051, 1'b0, 3);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h051, 12'h052, 1'b0, 4);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 12'h005, 1'b0, 12'h051, 12'h005, 1'b0, 5);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 12'h006, 1'b0, 5);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h005, 12'h006, 1'b0, 5);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h005, 12'h006, 1'b0, 6);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h005, 12'h006, 1'b0, 6);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h006, 12'h007, 1'b0, 6);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h007, 12'h008, 1'b0, 7);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h008, 12'h009, 1'b0, 8);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h009, 12'h00A, 1'b0, 9);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 12'h009, 12'h00A, 1'b0, 9);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h009, 12'h00A, 1'b1, 10);
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h009, 12'h00A, 1'b1, 10);
    vecs[23] = mk(1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 12'h009, 12'h000, 1'b0, 10);
    vecs[24] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 12'h001, 1'b0, 10);

    // Reset state while rst is held.
    @(negedge clk);
    @(negedge clk);
    chk("reset instr", instr, 32'h0);
    chk_outs("reset", 1'b0, 12'h000, 12'h000, 1'b0, 0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].fe, vecs[i].rdy, vecs[i].rde, vecs[i].rpc);
      chk_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].ipc, vecs[i].addr,
               vecs[i].halt, vecs[i].cnt);
    end

    // PC wraparound: redirect to the last word, then run free.
    step(1'b1, 1'b1, 1'b1, 12'hFFF);
    chk_outs("wrap redirect", 1'b0, 12'h000, 12'hFFF, 1'b0, 11);
    step(1'b1, 1'b1, 1'b0, 12'h000);
    chk_outs("wrap fff", 1'b1, 12'hFFF, 12'h000, 1'b0, 11);
    step(1'b1, 1'b1, 1'b0, 12'h000);
    chk_outs("wrap 000", 1'b1, 12'h000, 12'h001, 1'b0, 12);
    step(1'b1, 1'b1, 1'b0, 12'h000);
    chk_outs("wrap 001", 1'b1, 12'h001, 12'h002, 1'b0, 13);

    // Asynchronous reset pulse between edges discards the held instruction immediately.
    rst = 1'b1;
    #1;
    chk("async rst instr", instr, 32'h0);
    chk_outs("async rst", 1'b0, 12'h000, 12'h000, 1'b0, 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_outs("restart idle->run", 1'b0, 12'h000, 12'h000, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 12'h000);
    chk_outs("restart load", 1'b1, 12'h000, 12'h001, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
